pulse_burst_ctrl: RTL and testbench
===================================

Name: pulse_burst_ctrl

Overview:
Sequencer for the team's single-bit toggle output. It turns a one-cycle start request into a programmed burst: N pulses, each with a programmable high time and low time, then a one-cycle done. It sits between a control/register block and any pin or strobe consumer that needs a counted, shaped pulse train instead of a free-running toggle.

Parameters:
CNT_W, 8, width of high/low phase length fields (cycles)
NUM_W, 8, width of pulse-count field and pulse_cnt status

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  burst request; accepted only in IDLE
abort  input  1  terminate burst; effective in any state
high_len  input  CNT_W  cycles y stays 1 per pulse; 0 treated as 1
low_len  input  CNT_W  cycles y stays 0 between pulses; 0 treated as 1
num_pulses  input  NUM_W  pulses per burst; 0 = empty burst
y  output  1  registered pulse output
busy  output  1  1 in HIGH and LOW states
done  output  1  one-cycle completion strobe
pulse_cnt  output  NUM_W  completed pulses in current/last burst

Behaviour:
- Reset (async assert, sync to clk on release): state=IDLE, y=0, busy=0, done=0, pulse_cnt=0, internal counters=0.
- All outputs are registered and decoded from the state register. There are no combinational input-to-output paths.
- States: IDLE, HIGH, LOW, DONE.
- IDLE:
  - start=1 and abort=0 at edge T: latch high_len, low_len and num_pulses into shadow registers; clear pulse_cnt.
  - If latched num_pulses != 0: go to HIGH. y=1 and busy=1 from cycle T+1.
  - If latched num_pulses == 0: go to DONE. done=1 in cycle T+1, no pulse.
- HIGH: y=1 for exactly max(high_len,1) cycles. On the final cycle, pulse_cnt increments, then:
  - pulse_cnt (after increment) == num_pulses: go to DONE.
  - Otherwise: go to LOW.
- LOW: y=0, busy=1 for exactly max(low_len,1) cycles, then HIGH. There is no trailing LOW after the last pulse.
- DONE: y=0, busy=0, done=1 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored (not queued).
- Input changes during a burst have no effect; only the shadow copies are used.
- abort=1 at any edge in HIGH, LOW or DONE: next state IDLE, y=0, busy=0, done=0. pulse_cnt holds its value.
- abort and start both 1 in IDLE: abort wins, start ignored.
- start held high: one burst per IDLE visit. A new burst starts the cycle after DONE->IDLE if start is still 1 in IDLE.
- Phase counters are CNT_W bits and count down from the latched length. No wrap: maximum length 2^CNT_W-1 cycles.
- pulse_cnt saturates at num_pulses (max 2^NUM_W-1) and never wraps.
- rst mid-burst: immediate return to reset values, regardless of clk.

Test Plan:
- Reset check: rst=1 asynchronously mid-cycle during HIGH -> y=0, busy=0, done=0, pulse_cnt=0 before the next clk edge.
- Basic burst: high_len=2, low_len=3, num_pulses=3, start at T -> y pattern from T+1 is 1,1,0,0,0,1,1,0,0,0,1,1; done=1 at T+13; pulse_cnt=3; busy=0 at T+13.
- Zero fields: high_len=0, low_len=0, num_pulses=2 -> y=1,0,1 from T+1; done at T+4. Separately, num_pulses=0 -> no y pulse, done=1 at T+1.
- Abort: burst of high_len=4, low_len=4, num_pulses=5; abort during 2nd LOW -> next cycle y=0, busy=0, no done pulse ever, pulse_cnt=2, state IDLE (new start accepted).
- Simultaneous events: start=abort=1 in IDLE -> stays IDLE. Start pulsed during busy and during DONE -> ignored. Inputs changed mid-burst -> waveform unchanged.
- Back-to-back: start held 1, high_len=1, low_len=1, num_pulses=1 -> y=1 at T+1, done at T+2, IDLE at T+3, second y=1 at T+4.

Source files
------------

// File: rtl/pulse_burst_ctrl.sv
// Burst sequencer: turns a one-cycle start into N shaped pulses on y, then one-cycle done.
// Phase lengths and pulse count are snapshotted at start so mid-burst input changes are ignored.
module pulse_burst_ctrl #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] high_sh;
    logic [CNT_W-1:0] low_sh;
    logic [NUM_W-1:0] num_sh;
    logic [NUM_W-1:0] pulse_inc;

    // Phase counter terminal value is 0, so load length-1; a zero length behaves as one cycle.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign pulse_inc = (pulse_cnt == num_sh) ? pulse_cnt : pulse_cnt + NUM_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
            phase_cnt <= '0;
            high_sh   <= '0;
            low_sh    <= '0;
            num_sh    <= '0;
        end else if (abort) begin
            state <= IDLE;
            y     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        high_sh   <= high_len;
                        low_sh    <= low_len;
                        num_sh    <= num_pulses;
                        pulse_cnt <= '0;
                        if (num_pulses != '0) begin
                            state     <= HIGH;
                            y         <= 1'b1;
                            busy      <= 1'b1;
                            phase_cnt <= len_m1(high_len);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (phase_cnt == '0) begin
                        pulse_cnt <= pulse_inc;
                        y         <= 1'b0;
                        if (pulse_inc == num_sh) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= LOW;
                            phase_cnt <= len_m1(low_sh);
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (phase_cnt == '0) begin
                        state     <= HIGH;
                        y         <= 1'b1;
                        phase_cnt <= len_m1(high_sh);
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    y     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Directed-vector bench for pulse_burst_ctrl; outputs sampled on the falling edge.
module tb_pulse_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] num_pulses;
    logic       y;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    int nvec = 0;
    int nerr = 0;

    pulse_burst_ctrl #(.CNT_W(8), .NUM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic ey, input logic eb, input logic ed);
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    // Program fields, present start across one rising edge (edge T); returns just after T.
    task automatic launch(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        @(negedge clk);
        high_len   = h;
        low_len    = l;
        num_pulses = n;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        logic [11:0] basic_y;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        high_len = '0; low_len = '0; num_pulses = '0;
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.pulse_cnt", 32'(pulse_cnt), 0);
        rst = 1'b0;

        // Basic burst with mid-burst input changes and stray starts
        basic_y = 12'b110001100011;
        launch(8'd2, 8'd3, 8'd3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("basic.k%0d", k), 32'({y, busy, done}), 32'({basic_y[12-k], 1'b1, 1'b0}));
            if (k == 4) begin
                high_len = 8'd7; low_len = 8'd1; num_pulses = 8'd9;
            end
            start = (k == 6);
        end
        @(negedge clk);
        chk_out("basic.k13", 1'b0, 1'b0, 1'b1);
        chk("basic.pulse_cnt", 32'(pulse_cnt), 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_out("basic.k14", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("basic.k15_noqueue", 1'b0, 1'b0, 1'b0);

        // Zero lengths behave as one cycle
        launch(8'd0, 8'd0, 8'd2);
        @(negedge clk); chk_out("zero.k1", 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk_out("zero.k2", 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk_out("zero.k3", 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk_out("zero.k4", 1'b0, 1'b0, 1'b1);
        chk("zero.pulse_cnt", 32'(pulse_cnt), 2);

        // Empty burst
        launch(8'd3, 8'd3, 8'd0);
        @(negedge clk); chk_out("empty.k1", 1'b0, 1'b0, 1'b1);
        chk("empty.pulse_cnt", 32'(pulse_cnt), 0);
        @(negedge clk); chk_out("empty.k2", 1'b0, 1'b0, 1'b0);

        // Abort during the second LOW phase (cycles 13..16)
        launch(8'd4, 8'd4, 8'd5);
        for (int k = 1; k <= 14; k++) @(negedge clk);
        chk_out("abort.k14", 1'b0, 1'b1, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_out("abort.k15", 1'b0, 1'b0, 1'b0);
        chk("abort.pulse_cnt", 32'(pulse_cnt), 2);
        for (int k = 16; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("abort.nodone.k%0d", k), 32'({y, busy, done}), 0);
        end
        launch(8'd1, 8'd1, 8'd1);
        @(negedge clk); chk_out("abort.restart", 1'b1, 1'b1, 1'b0);
        chk("abort.restart.pulse_cnt", 32'(pulse_cnt), 0);
        @(negedge clk); chk_out("abort.restart.done", 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        high_len = 8'd2; low_len = 8'd2; num_pulses = 8'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_out("startabort.k1", 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk_out("startabort.k2", 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd1;
        start = 1'b1;
        @(negedge clk); chk_out("b2b.k1", 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk_out("b2b.k2", 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_out("b2b.k3", 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk_out("b2b.k4", 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk); chk_out("b2b.k5", 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_out("b2b.k6", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-HIGH, observed before the next rising edge
        launch(8'd5, 8'd2, 8'd3);
        @(negedge clk); @(negedge clk);
        chk_out("arst.pre", 1'b1, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_out("arst.async", 1'b0, 1'b0, 1'b0);
        chk("arst.pulse_cnt", 32'(pulse_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); chk_out("arst.idle", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
